// File: rtl/act_resp_collector.sv
// Collects a run of NUM_SAMPLES activation results and reports the count, min/max,
// the number of zero samples and a MISR signature. Control flow: IDLE -> COLLECT -> DONE.
module act_resp_collector #(
    parameter int                   WIDTH       = 8,
    parameter int                   NUM_SAMPLES = 256,
    parameter int                   SIG_WIDTH   = 16,
    parameter logic [SIG_WIDTH-1:0] POLY        = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED        = 16'hFFFF,
    localparam int                  CW          = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [WIDTH-1:0]     data,
    input  logic                        valid,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [CW-1:0]               count,
    output logic [SIG_WIDTH-1:0]        signature,
    output logic signed [WIDTH-1:0]     minVal,
    output logic signed [WIDTH-1:0]     maxVal,
    output logic [CW-1:0]               zeroCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CW-1:0]              LAST_IDX = CW'(NUM_SAMPLES - 1);
    localparam logic signed [WIDTH-1:0]    MIN_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]    MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                     state_q;
    logic                       busy_q, done_q, aborted_q;
    logic [CW-1:0]              count_q, zero_q;
    logic [SIG_WIDTH-1:0]       sig_q, sig_d;
    logic signed [WIDTH-1:0]    min_q, max_q;

    // Data bits are folded into the low end of the shifted register.
    always_comb begin
        sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
              ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
              ^ {{(SIG_WIDTH-WIDTH){1'b0}}, data};
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            count_q   <= '0;
            zero_q    <= '0;
            sig_q     <= SEED;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= COLLECT;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        count_q   <= '0;
                        zero_q    <= '0;
                        sig_q     <= SEED;
                        min_q     <= MIN_INIT;
                        max_q     <= MAX_INIT;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (valid) begin
                        count_q <= count_q + 1'b1;
                        sig_q   <= sig_d;
                        if (data == '0)    zero_q <= zero_q + 1'b1;
                        if (data < min_q)  min_q  <= data;
                        if (data > max_q)  max_q  <= data;
                        if (count_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign count     = count_q;
    assign zeroCount = zero_q;
    assign signature = sig_q;
    assign minVal    = min_q;
    assign maxVal    = max_q;

endmodule
